// File: rtl/updi_phy_ctrl_if.sv
// Link-layer request/response, PHY enable handshakes and PHY frame-memory port for updi_phy_ctrl.
// master = the sequencer; slave = link layer + PHY loader side.
interface updi_phy_ctrl_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_dir;
   logic [7:0]  req_data;
   logic        rsp_valid;
   logic [7:0]  rsp_data;
   logic [1:0]  rsp_err;
   logic        ten;
   logic        tend;
   logic        ren;
   logic        rend;
   logic        csb0;
   logic        web0;
   logic [6:0]  addr0;
   logic [11:0] i_data;
   logic [11:0] o_data;
   logic        busy;

   modport master (
      input  req_valid, req_dir, req_data, tend, rend, o_data,
      output req_ready, rsp_valid, rsp_data, rsp_err, ten, ren,
             csb0, web0, addr0, i_data, busy
   );

   modport slave (
      output req_valid, req_dir, req_data, tend, rend, o_data,
      input  req_ready, rsp_valid, rsp_data, rsp_err, ten, ren,
             csb0, web0, addr0, i_data, busy
   );
endinterface

// File: rtl/updi_phy_ctrl.sv
// Half-duplex UPDI PHY sequencer: builds/checks 12-bit frames in PHY memory and drives ten/ren.
// Optional RX timeout enabled by defining UPDI_PHY_CTRL_TIMEOUT_EN.
module updi_phy_ctrl #(
   parameter int       GUARD_CYC  = 16,
   parameter int       RX_TIMEOUT = 4096,
   parameter bit [6:0] TX_ADDR    = 7'h00,
   parameter bit [6:0] RX_ADDR    = 7'h40
) (
   input logic           clk,
   input logic           rst,
   updi_phy_ctrl_if.master bus
);

   localparam int CNT_MAX = (GUARD_CYC > RX_TIMEOUT) ? GUARD_CYC : RX_TIMEOUT;
   localparam int CW      = $clog2(CNT_MAX + 1);

   typedef enum logic [3:0] {
      IDLE, TX_LOAD, TX_START, TX_WAIT, GUARD,
      RX_START, RX_WAIT, RX_READ, RX_CHECK, RESP
   } state_t;

   state_t        state_q, state_d;
   logic [7:0]    data_q, data_d;
   logic          last_tx_q, last_tx_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [7:0]    rsp_data_q, rsp_data_d;
   logic [1:0]    rsp_err_q, rsp_err_d;

   logic        req_ready;
   logic        rsp_valid;
   logic        ten;
   logic        ren;
   logic        csb0;
   logic        web0;
   logic [6:0]  addr0;
   logic [11:0] i_data;
   logic [11:0] tx_frame;

   assign tx_frame = {2'b11, ^data_q, data_q, 1'b0};

   always_comb begin
      state_d    = state_q;
      data_d     = data_q;
      last_tx_d  = last_tx_q;
      cnt_d      = cnt_q;
      rsp_data_d = rsp_data_q;
      rsp_err_d  = rsp_err_q;
      req_ready  = 1'b0;
      rsp_valid  = 1'b0;
      ten        = 1'b0;
      ren        = 1'b0;
      csb0       = 1'b1;
      web0       = 1'b1;
      addr0      = 7'h00;
      i_data     = 12'h000;

      case (state_q)
         IDLE: begin
            // Reset is folded in so the link layer never sees ready during reset.
            req_ready = ~rst;
            if (bus.req_valid) begin
               data_d = bus.req_data;
               cnt_d  = '0;
               if (!bus.req_dir)
                  state_d = TX_LOAD;
               else if (last_tx_q && (GUARD_CYC > 0))
                  state_d = GUARD;
               else
                  state_d = RX_START;
            end
         end
         TX_LOAD: begin
            csb0    = 1'b0;
            web0    = 1'b0;
            addr0   = TX_ADDR;
            i_data  = tx_frame;
            state_d = TX_START;
         end
         TX_START, TX_WAIT: begin
            ten = 1'b1;
            if (bus.tend) begin
               rsp_data_d = 8'h00;
               rsp_err_d  = 2'b00;
               last_tx_d  = 1'b1;
               state_d    = RESP;
            end else begin
               state_d = TX_WAIT;
            end
         end
         GUARD: begin
            if (cnt_q == CW'(GUARD_CYC - 1)) begin
               cnt_d   = '0;
               state_d = RX_START;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RX_START: begin
            ren = 1'b1;
`ifdef UPDI_PHY_CTRL_TIMEOUT_EN
            cnt_d = cnt_q + 1'b1;
`endif
            state_d = bus.rend ? RX_READ : RX_WAIT;
         end
         RX_WAIT: begin
            ren = 1'b1;
            if (bus.rend) begin
               state_d = RX_READ;
`ifdef UPDI_PHY_CTRL_TIMEOUT_EN
            end else if (cnt_q == CW'(RX_TIMEOUT - 1)) begin
               // Abandon the receive; the memory holds nothing worth reading.
               rsp_data_d = 8'h00;
               rsp_err_d  = 2'b11;
               last_tx_d  = 1'b0;
               state_d    = RESP;
            end else begin
               cnt_d = cnt_q + 1'b1;
`endif
            end
         end
         RX_READ: begin
            csb0    = 1'b0;
            addr0   = RX_ADDR;
            state_d = RX_CHECK;
         end
         RX_CHECK: begin
            rsp_data_d = bus.o_data[8:1];
            if (bus.o_data[0] || (bus.o_data[11:10] != 2'b11))
               rsp_err_d = 2'b10;
            else if (bus.o_data[9] != ^bus.o_data[8:1])
               rsp_err_d = 2'b01;
            else
               rsp_err_d = 2'b00;
            last_tx_d = 1'b0;
            state_d   = RESP;
         end
         RESP: begin
            rsp_valid = 1'b1;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         data_q     <= 8'h00;
         last_tx_q  <= 1'b0;
         cnt_q      <= '0;
         rsp_data_q <= 8'h00;
         rsp_err_q  <= 2'b00;
      end else begin
         state_q    <= state_d;
         data_q     <= data_d;
         last_tx_q  <= last_tx_d;
         cnt_q      <= cnt_d;
         rsp_data_q <= rsp_data_d;
         rsp_err_q  <= rsp_err_d;
      end
   end

   assign bus.req_ready = req_ready;
   assign bus.rsp_valid = rsp_valid;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.ten       = ten;
   assign bus.ren       = ren;
   assign bus.csb0      = csb0;
   assign bus.web0      = web0;
   assign bus.addr0     = addr0;
   assign bus.i_data    = i_data;
   assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_updi_phy_ctrl.sv
// Directed bench for updi_phy_ctrl: TX/RX frames, guard spacing, error codes, reset mid-transfer.
// Define UPDI_PHY_CTRL_TIMEOUT_EN to also exercise the RX timeout.
module tb_updi_phy_ctrl;

   localparam int G  = 16;
   localparam int TO = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   updi_phy_ctrl_if bus ();

   updi_phy_ctrl #(
      .GUARD_CYC (G),
      .RX_TIMEOUT(TO),
      .TX_ADDR   (7'h00),
      .RX_ADDR   (7'h40)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ten and ren must never overlap
   always @(negedge clk)
      if (!rst) chk("ten_ren_excl", {15'b0, bus.ten & bus.ren}, 16'h0);

   task automatic do_tx(input logic [7:0] d, input logic [11:0] f);
      bus.req_valid = 1'b1;
      bus.req_dir   = 1'b0;
      bus.req_data  = d;
      chk("tx_req_ready", {15'b0, bus.req_ready}, 16'h1);
      tick();
      bus.req_valid = 1'b0;
      chk("tx_load_csb0", {15'b0, bus.csb0}, 16'h0);
      chk("tx_load_web0", {15'b0, bus.web0}, 16'h0);
      chk("tx_load_addr", {9'b0, bus.addr0}, 16'h00);
      chk("tx_load_frame", {4'b0, bus.i_data}, {4'b0, f});
      chk("tx_load_ten", {15'b0, bus.ten}, 16'h0);
      tick();
      chk("tx_ten_rise", {15'b0, bus.ten}, 16'h1);
      chk("tx_csb0_idle", {15'b0, bus.csb0}, 16'h1);
      tick();
      tick();
      chk("tx_ten_hold", {15'b0, bus.ten}, 16'h1);
      bus.tend = 1'b1;
      tick();
      bus.tend = 1'b0;
      chk("tx_rsp_valid", {15'b0, bus.rsp_valid}, 16'h1);
      chk("tx_rsp_err", {14'b0, bus.rsp_err}, 16'h0);
      chk("tx_rsp_data", {8'b0, bus.rsp_data}, 16'h0);
      chk("tx_ten_drop", {15'b0, bus.ten}, 16'h0);
      tick();
      chk("tx_rsp_pulse", {15'b0, bus.rsp_valid}, 16'h0);
      chk("tx_busy_clr", {15'b0, bus.busy}, 16'h0);
   endtask

   task automatic do_rx(input logic [11:0] od, input int exp_wait,
                        input logic [7:0] ed, input logic [1:0] ee);
      int n;
      bus.o_data    = od;
      bus.req_valid = 1'b1;
      bus.req_dir   = 1'b1;
      tick();
      bus.req_valid = 1'b0;
      n = 1;
      while (!bus.ren && n < 200) begin
         tick();
         n++;
      end
      chk("rx_ren_delay", 16'(n), 16'(exp_wait));
      chk("rx_wait_csb0", {15'b0, bus.csb0}, 16'h1);
      tick();
      tick();
      chk("rx_ren_hold", {15'b0, bus.ren}, 16'h1);
      bus.rend = 1'b1;
      tick();
      bus.rend = 1'b0;
      chk("rx_read_ren", {15'b0, bus.ren}, 16'h0);
      chk("rx_read_csb0", {15'b0, bus.csb0}, 16'h0);
      chk("rx_read_web0", {15'b0, bus.web0}, 16'h1);
      chk("rx_read_addr", {9'b0, bus.addr0}, 16'h40);
      tick();
      chk("rx_check_csb0", {15'b0, bus.csb0}, 16'h1);
      chk("rx_check_novld", {15'b0, bus.rsp_valid}, 16'h0);
      tick();
      chk("rx_rsp_valid", {15'b0, bus.rsp_valid}, 16'h1);
      chk("rx_rsp_data", {8'b0, bus.rsp_data}, {8'b0, ed});
      chk("rx_rsp_err", {14'b0, bus.rsp_err}, {14'b0, ee});
      tick();
      chk("rx_rsp_pulse", {15'b0, bus.rsp_valid}, 16'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.req_valid = 1'b0;
      bus.req_dir   = 1'b0;
      bus.req_data  = 8'h00;
      bus.tend      = 1'b0;
      bus.rend      = 1'b0;
      bus.o_data    = 12'h000;
      tick();
      tick();
      chk("rst_req_ready", {15'b0, bus.req_ready}, 16'h0);
      chk("rst_rsp_valid", {15'b0, bus.rsp_valid}, 16'h0);
      chk("rst_ten", {15'b0, bus.ten}, 16'h0);
      chk("rst_ren", {15'b0, bus.ren}, 16'h0);
      chk("rst_busy", {15'b0, bus.busy}, 16'h0);
      chk("rst_csb0", {15'b0, bus.csb0}, 16'h1);
      chk("rst_web0", {15'b0, bus.web0}, 16'h1);
      chk("rst_addr0", {9'b0, bus.addr0}, 16'h0);
      chk("rst_i_data", {4'b0, bus.i_data}, 16'h0);
      chk("rst_rsp_data", {8'b0, bus.rsp_data}, 16'h0);
      chk("rst_rsp_err", {14'b0, bus.rsp_err}, 16'h0);
      rst = 1'b0;
      #1;
      chk("rel_req_ready", {15'b0, bus.req_ready}, 16'h1);

      // Stray PHY done pulses while idle change nothing
      bus.tend = 1'b1;
      bus.rend = 1'b1;
      tick();
      bus.tend = 1'b0;
      bus.rend = 1'b0;
      chk("stray_busy", {15'b0, bus.busy}, 16'h0);
      chk("stray_rsp_valid", {15'b0, bus.rsp_valid}, 16'h0);

      // First RX after reset: no guard
      do_rx(12'hCAA, 1, 8'h55, 2'b00);
      do_tx(8'h55, 12'hCAA);
      do_rx(12'hCAA, G + 1, 8'h55, 2'b00);
      do_tx(8'h07, 12'hE0E);
      do_rx(12'hEAA, G + 1, 8'h55, 2'b01);
      do_rx(12'h4AA, 1, 8'h55, 2'b10);
      do_rx(12'h4AB, 1, 8'h55, 2'b10);

`ifdef UPDI_PHY_CTRL_TIMEOUT_EN
      begin
         int n;
         bus.req_valid = 1'b1;
         bus.req_dir   = 1'b1;
         tick();
         bus.req_valid = 1'b0;
         n = 0;
         while (bus.ren && n < 200) begin
            n++;
            tick();
         end
         chk("to_ren_cycles", 16'(n), 16'(TO));
         chk("to_rsp_valid", {15'b0, bus.rsp_valid}, 16'h1);
         chk("to_rsp_err", {14'b0, bus.rsp_err}, 16'h3);
         chk("to_rsp_data", {8'b0, bus.rsp_data}, 16'h0);
         tick();
      end
`endif

      // Reset while waiting for tend
      bus.req_valid = 1'b1;
      bus.req_dir   = 1'b0;
      bus.req_data  = 8'h55;
      tick();
      bus.req_valid = 1'b0;
      tick();
      tick();
      chk("mid_ten_high", {15'b0, bus.ten}, 16'h1);
      rst = 1'b1;
      #1;
      chk("mid_rst_ten", {15'b0, bus.ten}, 16'h0);
      chk("mid_rst_csb0", {15'b0, bus.csb0}, 16'h1);
      chk("mid_rst_busy", {15'b0, bus.busy}, 16'h0);
      chk("mid_rst_req_ready", {15'b0, bus.req_ready}, 16'h0);
      tick();
      rst = 1'b0;
      #1;
      do_tx(8'h55, 12'hCAA);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/updi_phy_ctrl.md
# updi_phy_ctrl

Half-duplex sequencer for the UPDI physical layer loader. It takes byte-level transmit/receive requests from the link layer and builds 12-bit UPDI frames into the PHY frame memory. It starts and awaits PHY transfers over the `ten`/`tend` and `ren`/`rend` handshakes, then reads received frames back and checks them. It sits between the link-layer command engine and the PHY loader, and is the only master of the PHY memory port and enables.

## Interface
- `GUARD_CYC`, 16 — idle `clk` cycles inserted between the end of a TX frame and the start of an RX request.
- `RX_TIMEOUT`, 4096 — cycles to wait for `rend` before aborting an RX (only with the timeout feature).
- `TX_ADDR`, 7'h00 — PHY memory word used for the TX frame.
- `RX_ADDR`, 7'h40 — PHY memory word the PHY fills with the RX frame.

Ports:
- `clk` in 1 — single clock; all logic rises on posedge.
- `rst` in 1 — asynchronous, active-high reset.
- `req_valid` in 1 — link-layer request valid.
- `req_ready` out 1 — controller can accept a request.
- `req_dir` in 1 — 0 = transmit byte, 1 = receive byte.
- `req_data` in 8 — byte to transmit (ignored for RX).
- `rsp_valid` out 1 — one-cycle pulse on completion of any request.
- `rsp_data` out 8 — received byte (0 for TX).
- `rsp_err` out 2 — 00 ok, 01 parity, 10 frame (start/stop), 11 timeout.
- `ten` out 1 — PHY transmit enable.
- `tend` in 1 — PHY transmit done, one-cycle pulse.
- `ren` out 1 — PHY receive enable.
- `rend` in 1 — PHY receive done, one-cycle pulse.
- `csb0` out 1 — PHY memory chip select, active low.
- `web0` out 1 — PHY memory write enable, active low.
- `addr0` out 7 — PHY memory address.
- `i_data` out 12 — frame written to PHY memory.
- `o_data` in 12 — frame read from PHY memory, valid the cycle after the read strobe.
- `busy` out 1 — state is not IDLE.

## Operation
- Frame layout: bit0 start = 0; bits[8:1] data, LSB first; bit9 even parity over data; bits[11:10] stop = 2'b11.
- States:
  - IDLE: `req_ready` = 1. Handshake on `req_valid & req_ready`; the request is captured. TX goes to TX_LOAD. RX goes to GUARD if the previous completed request was TX, else to RX_START.
  - TX_LOAD: `csb0` = 0, `web0` = 0, `addr0` = `TX_ADDR`, `i_data` = frame, for one cycle. Next state TX_START.
  - TX_START / TX_WAIT: `ten` = 1 until `tend` is sampled high. Then RESP with `rsp_err` = 00; the last-dir-TX flag is set.
  - GUARD: counts `GUARD_CYC` cycles, then RX_START.
  - RX_START / RX_WAIT: `ren` = 1 until `rend` is sampled high. Next state RX_READ.
  - RX_READ: `csb0` = 0, `web0` = 1, `addr0` = `RX_ADDR`, for one cycle. Next state RX_CHECK.
  - RX_CHECK: captures `o_data`.
    - Frame error if bit0 = 1 or bits[11:10] ≠ 11.
    - Otherwise parity error if the parity mismatches.
    - `rsp_data` = bits[8:1] regardless of error.
    - Next state RESP; the last-dir-TX flag is cleared.
  - RESP: `rsp_valid` = 1 for one cycle, then IDLE.
- `ten` and `ren` are never high in the same cycle.
- The memory port is idle (`csb0` = 1, `web0` = 1) outside TX_LOAD and RX_READ.
- `tend` or `rend` arriving in a state that is not waiting for it is ignored.

## Timing
- Reset values:
  - `req_ready` = 0 while `rst` is high, 1 in the first cycle after release.
  - `rsp_valid`, `ten`, `ren`, `busy` = 0.
  - `csb0` = 1, `web0` = 1.
  - `addr0` = 0, `i_data` = 0, `rsp_data` = 0, `rsp_err` = 00.
  - Last-dir flag cleared.
- TX latency: handshake at cycle N; write at N+1; `ten` rises at N+2. `rsp_valid` is asserted one cycle after the cycle in which `tend` is sampled high.
- RX latency, no guard: `ren` rises at N+1. After `rend` at cycle M: read at M+1, check at M+2, `rsp_valid` at M+3.
- GUARD adds exactly `GUARD_CYC` cycles between handshake and `ren` rising.
- Reset asserted mid-operation: all outputs return to reset values immediately (asynchronously); any in-flight PHY transfer is abandoned.

## Configuration
- `UPDI_PHY_CTRL_TIMEOUT_EN` defined:
  - RX_WAIT counts cycles. After `RX_TIMEOUT` cycles without `rend`, `ren` drops and the block goes to RESP with `rsp_err` = 11 and `rsp_data` = 0, skipping the read.
  - The counter clears on entering RX_START.
- Undefined: RX_WAIT waits indefinitely and the counter is not built.

## Test plan
- TX 0x55 → one write, `addr0` = 0x00, `i_data` = 0xCAA; `ten` held until `tend`; `rsp_valid` with `rsp_err` = 00.
- TX 0x07 → `i_data` = 0xE0E (parity bit 1).
- RX immediately after TX, with `o_data` = 0xCAA → exactly `GUARD_CYC` cycles before `ren`; read at `addr0` = 0x40; `rsp_data` = 0x55, `rsp_err` = 00.
- RX with `o_data` = 0xEAA → `rsp_err` = 01. RX with 0x4AA → `rsp_err` = 10. RX with 0x4AB → `rsp_err` = 10 (frame error has priority).
- RX with `rend` never asserted, macro defined and `RX_TIMEOUT` = 32 → `ren` drops after 32 cycles; `rsp_err` = 11.
- `rst` pulsed during TX_WAIT → `ten` = 0 and `csb0` = 1 immediately; next TX 0x55 completes normally.
